pciecfg_ctrl: RTL and testbench

Sequencer between the NetTLP PCIe-configuration request FIFO and the PCIe core's configuration management port. It pops one request (`FIFO_PCIECFG_T`) at a time, executes it as a single cfg_mgmt read or write, bounds the wait with a timeout, and pushes a completion record of the same type into the response FIFO for the UDP TX path. Exactly one transaction is in flight at a time.

---
 rtl/pciecfg_pkg.sv | 30 +++
 rtl/pciecfg_ctrl_if.sv | 36 +++
 rtl/pciecfg_ctrl.sv | 128 ++++++++++++
 tb/tb_pciecfg_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pciecfg_pkg.sv
// Shared NetTLP PCIe-configuration types: the FIFO record layout, opcodes and
// the controller state encoding.
package pciecfg_pkg;

    localparam logic [1:0]  PCIECFG_OPC_RD       = 2'b00;
    localparam logic [1:0]  PCIECFG_OPC_WR       = 2'b01;
    localparam logic [9:0]  PCIECFG_REG_BAR0     = 10'h004;
    localparam logic [31:0] PCIECFG_TIMEOUT_DATA = 32'hFFFF_FFFF;

    // Same layout for requests and completions; data carries the result on the way back.
    typedef struct packed {
        logic [15:0] udp_check;
        logic [1:0]  opcode;
        logic [3:0]  byte_mask;
        logic [9:0]  dwaddr;
        logic [31:0] data;
    } FIFO_PCIECFG_T;

    typedef enum logic [1:0] {
        CTRL_IDLE  = 2'd0,
        CTRL_LOAD  = 2'd1,
        CTRL_ISSUE = 2'd2,
        CTRL_RESP  = 2'd3
    } PCIECFG_CTRL_STATE_T;

    function automatic logic PCIECFG_OPC_VALID(input logic [1:0] opc);
        return (opc == PCIECFG_OPC_RD) || (opc == PCIECFG_OPC_WR);
    endfunction

endpackage

// File: rtl/pciecfg_ctrl_if.sv
// Bundle of the request FIFO, response FIFO and cfg_mgmt port seen by the
// configuration sequencer; master is the sequencer side.
interface pciecfg_ctrl_if;

    // Handshakes: a FIFO pop/push happens in every cycle its enable is high
    // (rd_en only when !empty, wr_en only when !full); popped data is valid
    // one cycle after req_rd_en. cfg_mgmt strobes stay high until the cycle
    // in which cfg_mgmt_rd_wr_done is seen, which completes the access.
    pciecfg_pkg::FIFO_PCIECFG_T req_dout;
    logic                       req_empty;
    logic                       req_rd_en;
    pciecfg_pkg::FIFO_PCIECFG_T rsp_din;
    logic                       rsp_full;
    logic                       rsp_wr_en;
    logic [9:0]                 cfg_mgmt_dwaddr;
    logic [3:0]                 cfg_mgmt_byte_en;
    logic [31:0]                cfg_mgmt_di;
    logic                       cfg_mgmt_rd_en;
    logic                       cfg_mgmt_wr_en;
    logic                       cfg_mgmt_wr_readonly;
    logic [31:0]                cfg_mgmt_do;
    logic                       cfg_mgmt_rd_wr_done;

    modport master (
        input  req_dout, req_empty, rsp_full, cfg_mgmt_do, cfg_mgmt_rd_wr_done,
        output req_rd_en, rsp_din, rsp_wr_en, cfg_mgmt_dwaddr, cfg_mgmt_byte_en,
               cfg_mgmt_di, cfg_mgmt_rd_en, cfg_mgmt_wr_en, cfg_mgmt_wr_readonly
    );

    modport slave (
        output req_dout, req_empty, rsp_full, cfg_mgmt_do, cfg_mgmt_rd_wr_done,
        input  req_rd_en, rsp_din, rsp_wr_en, cfg_mgmt_dwaddr, cfg_mgmt_byte_en,
               cfg_mgmt_di, cfg_mgmt_rd_en, cfg_mgmt_wr_en, cfg_mgmt_wr_readonly
    );

endinterface

// File: rtl/pciecfg_ctrl.sv
// One-at-a-time sequencer: pops a config request, runs it on cfg_mgmt with a
// bounded wait, and pushes the completion record to the response FIFO.
module pciecfg_ctrl
    import pciecfg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                pcie_clk,
    input  logic                pcie_rst,
    pciecfg_ctrl_if.master      bus,
    output logic [31:0]         stat_req_cnt,
    output logic [31:0]         stat_timeout_cnt,
    output logic [31:0]         stat_drop_cnt,
    output PCIECFG_CTRL_STATE_T dbg_state_o
);

    localparam int             TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_SAT  = TMO_W'(TIMEOUT_CYCLES);

    PCIECFG_CTRL_STATE_T state_q;
    FIFO_PCIECFG_T       req_q;
    logic [TMO_W-1:0]    tmo_q;
    logic [TMO_W-1:0]    tmo_d;
    logic [9:0]          dwaddr_q;
    logic [3:0]          byte_en_q;
    logic [31:0]         di_q;
    logic                rd_en_q;
    logic                wr_en_q;
    logic [31:0]         req_cnt_q;
    logic [31:0]         req_cnt_d;
    logic [31:0]         tmo_cnt_q;
    logic [31:0]         tmo_cnt_d;
    logic [31:0]         drop_cnt_q;
    logic [31:0]         drop_cnt_d;

    // Saturating wait counter; statistics wrap naturally.
    always_comb begin
        tmo_d      = (tmo_q >= TMO_SAT) ? tmo_q : tmo_q + 1'b1;
        req_cnt_d  = req_cnt_q + 32'd1;
        tmo_cnt_d  = tmo_cnt_q + 32'd1;
        drop_cnt_d = drop_cnt_q + 32'd1;
    end

    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            state_q    <= CTRL_IDLE;
            req_q      <= '0;
            tmo_q      <= '0;
            dwaddr_q   <= '0;
            byte_en_q  <= '0;
            di_q       <= '0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            req_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            case (state_q)
                CTRL_IDLE: begin
                    if (!bus.req_empty) begin
                        state_q <= CTRL_LOAD;
                    end
                end
                CTRL_LOAD: begin
                    // req_q doubles as the completion record; only data changes later.
                    req_q <= bus.req_dout;
                    if (!PCIECFG_OPC_VALID(bus.req_dout.opcode)) begin
                        drop_cnt_q <= drop_cnt_d;
                        state_q    <= CTRL_IDLE;
                    end else if (bus.req_dout.opcode == PCIECFG_OPC_WR &&
                                 bus.req_dout.byte_mask == 4'h0) begin
                        state_q <= CTRL_RESP;
                    end else begin
                        tmo_q     <= '0;
                        dwaddr_q  <= bus.req_dout.dwaddr;
                        byte_en_q <= bus.req_dout.byte_mask;
                        di_q      <= bus.req_dout.data;
                        rd_en_q   <= (bus.req_dout.opcode == PCIECFG_OPC_RD);
                        wr_en_q   <= (bus.req_dout.opcode == PCIECFG_OPC_WR);
                        state_q   <= CTRL_ISSUE;
                    end
                end
                CTRL_ISSUE: begin
                    if (bus.cfg_mgmt_rd_wr_done) begin
                        rd_en_q <= 1'b0;
                        wr_en_q <= 1'b0;
                        if (req_q.opcode == PCIECFG_OPC_RD) begin
                            req_q.data <= bus.cfg_mgmt_do;
                        end
                        state_q <= CTRL_RESP;
                    end else if (tmo_q == TMO_LAST) begin
                        rd_en_q    <= 1'b0;
                        wr_en_q    <= 1'b0;
                        req_q.data <= PCIECFG_TIMEOUT_DATA;
                        tmo_cnt_q  <= tmo_cnt_d;
                        state_q    <= CTRL_RESP;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                CTRL_RESP: begin
                    if (!bus.rsp_full) begin
                        req_cnt_q <= req_cnt_d;
                        state_q   <= CTRL_IDLE;
                    end
                end
                default: state_q <= CTRL_IDLE;
            endcase
        end
    end

    assign bus.req_rd_en            = (state_q == CTRL_IDLE) && !bus.req_empty;
    assign bus.rsp_wr_en            = (state_q == CTRL_RESP) && !bus.rsp_full;
    assign bus.rsp_din              = req_q;
    assign bus.cfg_mgmt_dwaddr      = dwaddr_q;
    assign bus.cfg_mgmt_byte_en     = byte_en_q;
    assign bus.cfg_mgmt_di          = di_q;
    assign bus.cfg_mgmt_rd_en       = rd_en_q;
    assign bus.cfg_mgmt_wr_en       = wr_en_q;
    assign bus.cfg_mgmt_wr_readonly = 1'b0;

    assign stat_req_cnt     = req_cnt_q;
    assign stat_timeout_cnt = tmo_cnt_q;
    assign stat_drop_cnt    = drop_cnt_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_pciecfg_ctrl.sv
// Directed bench for pciecfg_ctrl: FIFO and cfg_mgmt models around the DUT,
// a response scoreboard, and per-scenario checks on strobes and statistics.
module tb_pciecfg_ctrl;
    import pciecfg_pkg::*;

    localparam int TMO = 16;

    logic                pcie_clk = 1'b0;
    logic                pcie_rst;
    logic [31:0]         stat_req_cnt;
    logic [31:0]         stat_timeout_cnt;
    logic [31:0]         stat_drop_cnt;
    PCIECFG_CTRL_STATE_T dbg_state;

    pciecfg_ctrl_if bus ();

    pciecfg_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .pcie_clk         (pcie_clk),
        .pcie_rst         (pcie_rst),
        .bus              (bus),
        .stat_req_cnt     (stat_req_cnt),
        .stat_timeout_cnt (stat_timeout_cnt),
        .stat_drop_cnt    (stat_drop_cnt),
        .dbg_state_o      (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 pcie_clk = ~pcie_clk;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic FIFO_PCIECFG_T mk(input logic [15:0] udp, input logic [1:0] opc,
                                         input logic [3:0] mask, input logic [9:0] addr,
                                         input logic [31:0] data);
        FIFO_PCIECFG_T r;
        r.udp_check = udp;
        r.opcode    = opc;
        r.byte_mask = mask;
        r.dwaddr    = addr;
        r.data      = data;
        return r;
    endfunction

    // ---------------- request FIFO model ----------------
    FIFO_PCIECFG_T req_fifo[$];
    logic          pop_pend = 1'b0;
    int            pop_cnt  = 0;

    always @(negedge pcie_clk) pop_pend = (bus.req_rd_en === 1'b1);

    always @(posedge pcie_clk) begin
        #1;
        if (pop_pend && req_fifo.size() > 0) begin
            bus.req_dout = req_fifo.pop_front();
            pop_cnt++;
        end
        bus.req_empty = (req_fifo.size() == 0);
    end

    // ---------------- cfg_mgmt responder ----------------
    int          done_after = 0;
    bit          never_done = 1'b0;
    logic [31:0] rd_value   = 32'h0;
    int          scnt       = 0;
    int          strobe_hi  = 0;
    logic [9:0]  first_addr;
    logic [31:0] first_di;
    logic [9:0]  done_addr;
    logic [31:0] done_di;
    logic [3:0]  done_be;
    logic        done_wr;
    logic        done_rd;

    always @(posedge pcie_clk) begin
        #1;
        if (bus.cfg_mgmt_rd_en === 1'b1 || bus.cfg_mgmt_wr_en === 1'b1) begin
            scnt++;
            strobe_hi++;
            if (scnt == 1) begin
                first_addr = bus.cfg_mgmt_dwaddr;
                first_di   = bus.cfg_mgmt_di;
            end
        end else begin
            scnt = 0;
        end
        bus.cfg_mgmt_rd_wr_done = (scnt != 0) && !never_done && (scnt == done_after + 1);
        bus.cfg_mgmt_do         = bus.cfg_mgmt_rd_wr_done ? rd_value : 32'h0;
        if (bus.cfg_mgmt_rd_wr_done) begin
            done_addr = bus.cfg_mgmt_dwaddr;
            done_di   = bus.cfg_mgmt_di;
            done_be   = bus.cfg_mgmt_byte_en;
            done_wr   = bus.cfg_mgmt_wr_en;
            done_rd   = bus.cfg_mgmt_rd_en;
        end
    end

    // ---------------- response scoreboard ----------------
    logic [63:0] exp_q[$];
    int          rsp_seen = 0;

    always @(negedge pcie_clk) begin
        #1;
        if (bus.rsp_wr_en === 1'b1) begin
            rsp_seen++;
            if (exp_q.size() == 0) check("unexpected_push", bus.rsp_din, 64'hx);
            else check("rsp_din", bus.rsp_din, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_req(input FIFO_PCIECFG_T r);
        req_fifo.push_back(r);
    endtask

    task automatic wait_rsp(input int target, input int budget);
        for (int i = 0; i < budget && rsp_seen < target; i++) @(negedge pcie_clk);
        @(negedge pcie_clk);
        check("rsp_wait", 64'(rsp_seen >= target), 64'd1);
    endtask

    task automatic wait_state(input PCIECFG_CTRL_STATE_T st, input int budget);
        for (int i = 0; i < budget && dbg_state != st; i++) @(negedge pcie_clk);
        check("state_wait", 64'(dbg_state), 64'(st));
    endtask

    // ---------------- main sequence ----------------
    int s0, p0, r0, bad;

    initial begin
        pcie_rst = 1'b1;
        bus.rsp_full = 1'b0;
        repeat (3) @(negedge pcie_clk);
        check("rst_state", 64'(dbg_state), 64'(CTRL_IDLE));
        check("rst_rd_en", 64'(bus.cfg_mgmt_rd_en), 64'd0);
        check("rst_wr_en", 64'(bus.cfg_mgmt_wr_en), 64'd0);
        check("rst_req_rd_en", 64'(bus.req_rd_en), 64'd0);
        check("rst_rsp_wr_en", 64'(bus.rsp_wr_en), 64'd0);
        check("rst_readonly", 64'(bus.cfg_mgmt_wr_readonly), 64'd0);
        check("rst_stats", {stat_req_cnt, stat_timeout_cnt | stat_drop_cnt}, 64'd0);
        pcie_rst = 1'b0;
        @(negedge pcie_clk);

        // read completes 3 cycles after rd_en rises
        done_after = 3; rd_value = 32'h7011_10EE; s0 = strobe_hi;
        exp_q.push_back(mk(16'hA5A5, PCIECFG_OPC_RD, 4'hF, 10'h000, 32'h7011_10EE));
        push_req(mk(16'hA5A5, PCIECFG_OPC_RD, 4'hF, 10'h000, 32'h0));
        wait_rsp(1, 40);
        check("rd_strobe_cycles", 64'(strobe_hi - s0), 64'd4);
        check("rd_req_cnt", 64'(stat_req_cnt), 64'd1);

        // write to BAR0 held until done
        done_after = 1; rd_value = 32'h1234_5678; s0 = strobe_hi;
        exp_q.push_back(mk(16'h1234, PCIECFG_OPC_WR, 4'hF, 10'h004, 32'hFFFF_FFFF));
        push_req(mk(16'h1234, PCIECFG_OPC_WR, 4'hF, PCIECFG_REG_BAR0, 32'hFFFF_FFFF));
        wait_rsp(2, 40);
        check("wr_first_addr", 64'(first_addr), 64'h004);
        check("wr_first_di", 64'(first_di), 64'hFFFF_FFFF);
        check("wr_done_addr_di", {22'h0, done_addr, done_di}, {22'h0, 10'h004, 32'hFFFF_FFFF});
        check("wr_done_be_strobes", {done_be, done_wr, done_rd}, {4'hF, 1'b1, 1'b0});
        check("wr_strobe_cycles", 64'(strobe_hi - s0), 64'd2);
        check("wr_req_cnt", 64'(stat_req_cnt), 64'd2);

        // read that never completes
        never_done = 1'b1; s0 = strobe_hi;
        exp_q.push_back(mk(16'h0BEE, PCIECFG_OPC_RD, 4'h3, 10'h3FF, 32'hFFFF_FFFF));
        push_req(mk(16'h0BEE, PCIECFG_OPC_RD, 4'h3, 10'h3FF, 32'h0));
        wait_rsp(3, 60);
        check("tmo_strobe_cycles", 64'(strobe_hi - s0), 64'd16);
        check("tmo_cnt", 64'(stat_timeout_cnt), 64'd1);
        check("tmo_req_cnt", 64'(stat_req_cnt), 64'd3);
        never_done = 1'b0;

        // invalid opcode dropped, following read served
        done_after = 0; rd_value = 32'hDEAD_BEEF;
        exp_q.push_back(mk(16'h5555, PCIECFG_OPC_RD, 4'h1, 10'h010, 32'hDEAD_BEEF));
        push_req(mk(16'hAAAA, 2'b11, 4'hF, 10'h020, 32'h0000_0042));
        push_req(mk(16'h5555, PCIECFG_OPC_RD, 4'h1, 10'h010, 32'h0));
        wait_rsp(4, 40);
        check("drop_cnt", 64'(stat_drop_cnt), 64'd1);
        check("drop_req_cnt", 64'(stat_req_cnt), 64'd4);

        // zero-mask write bypasses cfg_mgmt
        s0 = strobe_hi;
        exp_q.push_back(mk(16'h0F0F, PCIECFG_OPC_WR, 4'h0, 10'h020, 32'hCAFE_F00D));
        push_req(mk(16'h0F0F, PCIECFG_OPC_WR, 4'h0, 10'h020, 32'hCAFE_F00D));
        wait_rsp(5, 40);
        check("mask0_no_strobe", 64'(strobe_hi - s0), 64'd0);
        check("mask0_req_cnt", 64'(stat_req_cnt), 64'd5);

        // response FIFO full for 10 cycles
        bus.rsp_full = 1'b1; rd_value = 32'h0000_1111;
        exp_q.push_back(mk(16'h7777, PCIECFG_OPC_RD, 4'hF, 10'h005, 32'h0000_1111));
        exp_q.push_back(mk(16'h8888, PCIECFG_OPC_RD, 4'hF, 10'h006, 32'h0000_1111));
        push_req(mk(16'h7777, PCIECFG_OPC_RD, 4'hF, 10'h005, 32'h0));
        wait_state(CTRL_RESP, 40);
        push_req(mk(16'h8888, PCIECFG_OPC_RD, 4'hF, 10'h006, 32'h0));
        p0 = pop_cnt; r0 = rsp_seen; bad = 0;
        repeat (10) begin
            @(negedge pcie_clk);
            if (bus.rsp_wr_en !== 1'b0 || bus.req_rd_en !== 1'b0) bad++;
        end
        check("full_hold_quiet", 64'(bad), 64'd0);
        check("full_no_pop", 64'(pop_cnt - p0), 64'd0);
        check("full_no_push", 64'(rsp_seen - r0), 64'd0);
        check("full_state", 64'(dbg_state), 64'(CTRL_RESP));
        bus.rsp_full = 1'b0;
        #1;
        check("push_on_release", 64'(bus.rsp_wr_en), 64'd1);
        wait_rsp(7, 40);
        check("full_req_cnt", 64'(stat_req_cnt), 64'd7);

        // reset in the middle of an access
        never_done = 1'b1; r0 = rsp_seen;
        push_req(mk(16'h9999, PCIECFG_OPC_RD, 4'hF, 10'h007, 32'h0));
        for (int i = 0; i < 20 && bus.cfg_mgmt_rd_en !== 1'b1; i++) @(negedge pcie_clk);
        check("mid_issue_strobe", 64'(bus.cfg_mgmt_rd_en), 64'd1);
        @(negedge pcie_clk);
        pcie_rst = 1'b1;
        @(negedge pcie_clk);
        check("rst_mid_strobe", 64'(bus.cfg_mgmt_rd_en), 64'd0);
        check("rst_mid_state", 64'(dbg_state), 64'(CTRL_IDLE));
        check("rst_mid_stats", {stat_req_cnt, stat_timeout_cnt | stat_drop_cnt}, 64'd0);
        pcie_rst = 1'b0;
        repeat (TMO + 4) @(negedge pcie_clk);
        check("rst_mid_no_push", 64'(rsp_seen - r0), 64'd0);
        never_done = 1'b0; done_after = 2; rd_value = 32'h0BAD_F00D;
        exp_q.push_back(mk(16'h4242, PCIECFG_OPC_RD, 4'hC, 10'h011, 32'h0BAD_F00D));
        push_req(mk(16'h4242, PCIECFG_OPC_RD, 4'hC, 10'h011, 32'h0));
        wait_rsp(r0 + 1, 40);
        check("post_rst_req_cnt", 64'(stat_req_cnt), 64'd1);
        check("post_rst_tmo_cnt", 64'(stat_timeout_cnt), 64'd0);

        // ---------------- report ----------------
        repeat (3) @(negedge pcie_clk);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
